// File: rtl/seq_multiplier_if.sv
// Host-side handshake and operand/result bundle for seq_multiplier.
// The master drives requests; the slave (the multiplier) returns status and product.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 4
);
  logic               start_i;
  logic               mode_i;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] out_data;

  modport master (
    output start_i,
    output mode_i,
    output a_in,
    output b_in,
    input  busy_o,
    input  done_o,
    input  out_data
  );

  modport slave (
    input  start_i,
    input  mode_i,
    input  a_in,
    input  b_in,
    output busy_o,
    output done_o,
    output out_data
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: repeated-addition (mode 0) or shift-add (mode 1)
// with a start/busy/done handshake and a held result register.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk_in,
  input logic              rst_in,
  seq_multiplier_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [PW-1:0]     f_q, f_d;
  logic [PW-1:0]     r_q, r_d;
  logic              m_q, m_d;
  logic [PW-1:0]     sum;

  // Single shared adder; cannot overflow since the product fits in PW bits.
  assign sum = f_q + p_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    f_d     = f_q;
    r_d     = r_q;
    m_d     = m_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          p_d     = {{WIDTH{1'b0}}, bus.a_in};
          q_d     = bus.b_in;
          f_d     = '0;
          m_d     = bus.mode_i;
          state_d = StRun;
        end
      end
      StRun: begin
        if (q_q == '0) begin
          r_d     = f_q;
          state_d = StDone;
        end else if (!m_q) begin
          f_d = sum;
          q_d = q_q - WIDTH'(1);
        end else begin
          if (q_q[0]) f_d = sum;
          p_d = p_q << 1;
          q_d = q_q >> 1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      p_q     <= '0;
      q_q     <= '0;
      f_q     <= '0;
      r_q     <= '0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      f_q     <= f_d;
      r_q     <= r_d;
      m_q     <= m_d;
    end
  end

  // Status is decoded from the state register only, so no input-to-output path.
  assign bus.busy_o   = (state_q != StIdle);
  assign bus.done_o   = (state_q == StDone);
  assign bus.out_data = r_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): vector table, scoreboard queue,
// hand-written corner sequences and a random sweep in both modes.
module tb_seq_multiplier;

  localparam int unsigned W = 8;

  typedef struct {
    logic        mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    int          lat;
  } sb_t;

  logic clk_in;
  logic rst_in;
  int   n_tests;
  int   n_fail;
  sb_t  sb[$];
  logic [15:0] last_result;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge index of the DONE transition counted from the start edge: N+1.
  function automatic int calc_lat(input logic mode, input logic [7:0] b);
    int n;
    n = 0;
    if (!mode) n = int'(b);
    else for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
    return n + 1;
  endfunction

  task automatic run_op(input logic mode, input logic [7:0] a, input logic [7:0] b,
                        input logic poke, input int exp_lat, input string tag);
    sb_t e;
    int  k, busy_cnt, done_cnt, done_edge, bad_done;
    e.p   = 16'(a) * 16'(b);
    e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk_in);
    bus.start_i = 1'b1;
    bus.mode_i  = mode;
    bus.a_in    = a;
    bus.b_in    = b;
    @(posedge clk_in);
    #1;
    bus.start_i = 1'b0;
    check({tag, " hold_prev"}, 32'(bus.out_data), 32'(last_result));
    k = 0; busy_cnt = 0; done_cnt = 0; done_edge = -1;
    while (k <= 600) begin
      if (!bus.busy_o) break;
      busy_cnt++;
      if (bus.done_o) begin
        done_cnt++;
        done_edge = k;
        if (sb.size() == 0) begin
          check({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, " product"}, 32'(bus.out_data), 32'(e.p));
          check({tag, " latency"}, 32'(k + 1), 32'(e.lat + 1));
          last_result = e.p;
        end
      end
      if (poke) begin
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b0;
        bus.a_in    = 8'd1;
        bus.b_in    = 8'd1;
      end
      @(posedge clk_in);
      #1;
      k++;
    end
    bus.start_i = 1'b0;
    check({tag, " timeout"}, 32'(k > 600), 32'd0);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    bad_done = 0;
    repeat (3) begin
      @(posedge clk_in);
      #1;
      if (bus.done_o || bus.busy_o) bad_done++;
    end
    check({tag, " idle_after"}, 32'(bad_done), 32'd0);
    check({tag, " out_held"}, 32'(bus.out_data), 32'(last_result));
    if (done_edge < 0) sb.delete();
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] ra, rb;
    logic       rm;
    int         bad;
    n_tests = 0;
    n_fail = 0;
    last_result = '0;
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.a_in    = '0;
    bus.b_in    = '0;

    // Reset and idle behaviour.
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst done", 32'(bus.done_o), 32'd0);
    check("rst out", 32'(bus.out_data), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      bus.a_in = 8'($urandom_range(0, 255));
      bus.b_in = 8'($urandom_range(0, 255));
      bus.mode_i = 1'($urandom_range(0, 1));
      @(posedge clk_in);
      #1;
      if (bus.busy_o || bus.done_o || bus.out_data != 16'd0) bad++;
    end
    check("idle no_start", 32'(bad), 32'd0);

    // Directed vectors with hand-computed products and DONE edge indices.
    vecs.push_back('{1'b0, 8'd5,   8'd3,   16'd15,    4});
    vecs.push_back('{1'b0, 8'd5,   8'd0,   16'd0,     1});
    vecs.push_back('{1'b1, 8'd15,  8'd15,  16'd225,   5});
    vecs.push_back('{1'b1, 8'd9,   8'd2,   16'd18,    3});
    vecs.push_back('{1'b1, 8'd255, 8'd255, 16'd65025, 9});
    vecs.push_back('{1'b0, 8'd0,   8'd7,   16'd0,     8});
    vecs.push_back('{1'b1, 8'd0,   8'd128, 16'd0,     9});
    vecs.push_back('{1'b1, 8'd200, 8'd0,   16'd0,     1});
    vecs.push_back('{1'b0, 8'd255, 8'd2,   16'd510,   3});
    vecs.push_back('{1'b1, 8'd3,   8'd1,   16'd3,     2});
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d model", i), 32'(16'(vecs[i].a) * 16'(vecs[i].b)),
            32'(vecs[i].exp_p));
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_lat,
             $sformatf("vec%0d", i));
    end

    // Start requests while busy are ignored.
    run_op(1'b0, 8'd7, 8'd9, 1'b1, 10, "busy_start");
    check("busy_start result", 32'(bus.out_data), 32'd63);

    // Reset mid-operation discards the operation.
    @(negedge clk_in);
    bus.start_i = 1'b1;
    bus.mode_i  = 1'b0;
    bus.a_in    = 8'd3;
    bus.b_in    = 8'd12;
    @(posedge clk_in);
    #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    check("midrst busy_before", 32'(bus.busy_o), 32'd1);
    rst_in = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy_o), 32'd0);
    check("midrst out", 32'(bus.out_data), 32'd0);
    check("midrst done", 32'(bus.done_o), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    last_result = '0;
    bad = 0;
    repeat (15) begin
      @(posedge clk_in);
      #1;
      if (bus.done_o || bus.busy_o) bad++;
    end
    check("midrst no_done", 32'(bad), 32'd0);
    run_op(1'b0, 8'd2, 8'd4, 1'b0, 5, "after_rst");

    // Random sweep in both modes.
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 1'(i % 2);
      run_op(rm, ra, rb, 1'b0, calc_lat(rm, rb), $sformatf("rnd%0d", i));
    end

    check("sb drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Self-contained sequential unsigned multiplier. It merges the P register, Q counter, F accumulator, adder and zero-detect datapath with its own controller FSM. The block is generalised to WIDTH-bit operands and adds a runtime-selectable shift-add mode alongside the existing repeated-addition algorithm. A start/busy/done handshake lets a host sequencer issue operations, and the result is held in a dedicated output register.

Parameters:
WIDTH, 4, operand width in bits (>=2); product width is 2*WIDTH.

Ports:
clk_in     input   1          clock, rising-edge
rst_in     input   1          reset, asynchronous, active-low
start_i    input   1          request operation; sampled only in IDLE
mode_i     input   1          0 = repeated-add, 1 = shift-add; latched with start
a_in       input   WIDTH      multiplicand, latched with start
b_in       input   WIDTH      multiplier, latched with start
busy_o     output  1          high while state != IDLE
done_o     output  1          one-cycle pulse, out_data valid and updated
out_data   output  2*WIDTH    product of the last completed operation

Behaviour:
- Reset (rst_in low, any time incl. mid-operation): state=IDLE. P, Q, F, result register and mode all cleared. busy_o=0, done_o=0, out_data=0. An in-flight operation is discarded.
- Internal registers:
  - P: 2*WIDTH, multiplicand zero-extended.
  - Q: WIDTH, multiplier / iteration counter.
  - F: 2*WIDTH accumulator.
  - R: 2*WIDTH result register, drives out_data.
  - M: latched mode.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 at an edge: P<={0,a_in}, Q<=b_in, F<=0, M<=mode_i, go RUN.
  - start_i=0: remain IDLE.
- RUN, evaluated every edge:
  - Q==0: R<=F, go DONE (no accumulate that edge).
  - M=0, Q!=0: F<=F+P, Q<=Q-1.
  - M=1, Q!=0: if Q[0] then F<=F+P; P<=P<<1; Q<=Q>>1 (logical).
- DONE: done_o=1 for exactly this one cycle. Next edge go IDLE unconditionally.
- start_i in RUN or DONE is ignored. It is neither queued nor does it alter the operands or mode. A host may assert start_i in the first IDLE cycle after DONE.
- Latency: with start sampled at edge 0, the transition to DONE occurs at edge N+1. done_o is high in the cycle following that edge, and busy_o is high for N+2 cycles.
  - M=0: N = b.
  - M=1: N = floor(log2(b))+1 for b>0.
  - b=0 (either mode): N = 0.
- Arithmetic:
  - Unsigned; adder is 2*WIDTH wide.
  - No overflow is possible, since max product (2^WIDTH-1)^2 < 2^(2*WIDTH). No carry-out port.
  - P<<1 discards bits beyond 2*WIDTH. They are never needed, because Q reaches 0 within WIDTH shifts.
- a=0 still iterates per the rules above; the result is 0.
- out_data changes only on entry to DONE or on reset; it holds across IDLE and the next RUN.
- busy_o and done_o are registered or decoded from the state register only: no combinational path from inputs.

Test Plan:
1. Reset/idle: hold rst_in low, then release; drive random a/b with start_i=0 for 20 cycles -> out_data=0, busy_o=0, done_o never asserted.
2. Repeated-add: WIDTH=4, mode=0, a=5, b=3, start for 1 cycle -> done_o pulses once, 4 edges after the start edge; out_data=15; busy_o high for 5 cycles. Repeat with b=0 -> out_data=0, done_o after 1 edge.
3. Shift-add: WIDTH=4, mode=1, a=15, b=15 -> out_data=225, done after 5 edges. Then a=9, b=2 -> out_data=18, done after 3 edges.
4. Start while busy: mode=0, a=7, b=9; re-assert start with a=1, b=1 during RUN and DONE -> single done_o, out_data=63, second request not executed.
5. Reset mid-operation: mode=0, a=3, b=12; pulse rst_in low during RUN -> immediately busy_o=0, out_data=0, no done_o. Next op a=2, b=4 -> out_data=8.
6. WIDTH=8 sweep: mode=1, a=255, b=255 -> out_data=65025 after 9 edges. Then 500 random operand pairs in both modes -> out_data equals a*b, and done latency matches the N formula.
